// File: rtl/pulse_timer.sv
`default_nettype none
// ============================================================================
// Module   : pulse_timer
// Brief    : Down-counting one-shot / periodic timer with selectable tick source
//            and a registered expiry pulse plus sticky interrupt flag.
// Revision : 1.0 - initial release
// ============================================================================
module pulse_timer #(
    parameter int WD = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          pulse_1us,
    input  logic          pulse_1ms,
    input  logic          pulse_1s,
    input  logic          cfg_enb,
    input  logic          cfg_mode,
    input  logic [1:0]    cfg_clksel,
    input  logic [WD-1:0] cfg_load_val,
    input  logic          cfg_start,
    input  logic          cfg_stop,
    input  logic          irq_clr,
    output logic [WD-1:0] timer_cnt,
    output logic          timer_busy,
    output logic          timer_done,
    output logic          timer_irq
);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_RUN  = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [WD-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;
    logic          irq_q, irq_d;

    logic          w_tick;
    logic          w_load;
    logic          w_dec;
    logic          w_expire;
    logic          w_cnt_zero;

    always_comb begin : p_tick_sel
        w_tick = 1'b0;
        case (cfg_clksel)
            2'b00:   w_tick = 1'b1;
            2'b01:   w_tick = pulse_1us;
            2'b10:   w_tick = pulse_1ms;
            default: w_tick = pulse_1s;
        endcase
    end

    assign w_cnt_zero = (cnt_q == '0);

    // Stop outranks start, start outranks tick; a disabled timer does nothing.
    always_comb begin : p_ctrl
        w_load   = 1'b0;
        w_dec    = 1'b0;
        w_expire = 1'b0;
        if (cfg_enb) begin
            case (state_q)
                c_IDLE: begin
                    w_load = cfg_start && !cfg_stop;
                end
                default: begin
                    if (cfg_stop) begin
                        w_load = 1'b0;
                    end else if (cfg_start) begin
                        w_load = 1'b1;
                    end else if (w_tick) begin
                        w_dec    = !w_cnt_zero;
                        w_expire = w_cnt_zero;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin : p_state_reg
        if (!reset_n) begin
            state_q <= c_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin : p_next_state
        state_d = state_q;
        if (!cfg_enb) begin
            state_d = c_IDLE;
        end else begin
            case (state_q)
                c_IDLE: begin
                    if (w_load) begin
                        state_d = c_RUN;
                    end
                end
                default: begin
                    if (cfg_stop) begin
                        state_d = c_IDLE;
                    end else if (w_expire && !cfg_mode) begin
                        state_d = c_IDLE;
                    end
                end
            endcase
        end
    end

    always_comb begin : p_outputs
        timer_busy = (state_q == c_RUN);
        timer_cnt  = cnt_q;
        timer_done = done_q;
        timer_irq  = irq_q;
    end

    // Expiry reloads in periodic mode; one-shot parks the count at zero.
    always_comb begin : p_datapath
        cnt_d = cnt_q;
        if (w_load) begin
            cnt_d = cfg_load_val;
        end else if (w_dec) begin
            cnt_d = cnt_q - WD'(1);
        end else if (w_expire) begin
            cnt_d = cfg_mode ? cfg_load_val : '0;
        end
        done_d = w_expire;
        irq_d  = w_expire | (irq_q & ~irq_clr);
    end

    always_ff @(posedge clk or negedge reset_n) begin : p_data_reg
        if (!reset_n) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= done_d;
            irq_q  <= irq_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pulse_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pulse_timer
// Brief    : Self-checking scenario bench for pulse_timer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pulse_timer;

    localparam int WD = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          pulse_1us, pulse_1ms, pulse_1s;
    logic          cfg_enb, cfg_mode, cfg_start, cfg_stop, irq_clr;
    logic [1:0]    cfg_clksel;
    logic [WD-1:0] cfg_load_val;
    logic [WD-1:0] timer_cnt;
    logic          timer_busy, timer_done, timer_irq;

    typedef struct {
        logic [WD-1:0] cnt;
        logic          busy;
        logic          done;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pulse_timer #(.WD(WD)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .pulse_1us    (pulse_1us),
        .pulse_1ms    (pulse_1ms),
        .pulse_1s     (pulse_1s),
        .cfg_enb      (cfg_enb),
        .cfg_mode     (cfg_mode),
        .cfg_clksel   (cfg_clksel),
        .cfg_load_val (cfg_load_val),
        .cfg_start    (cfg_start),
        .cfg_stop     (cfg_stop),
        .irq_clr      (irq_clr),
        .timer_cnt    (timer_cnt),
        .timer_busy   (timer_busy),
        .timer_done   (timer_done),
        .timer_irq    (timer_irq)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t mk(input logic [WD-1:0] c, input logic b, input logic d);
        exp_t r;
        r.cnt  = c;
        r.busy = b;
        r.done = d;
        return r;
    endfunction

    task automatic test_reset();
        reset_n = 1'b0; pulse_1us = 0; pulse_1ms = 0; pulse_1s = 0;
        cfg_enb = 1; cfg_mode = 0; cfg_clksel = 2'b00; cfg_load_val = '0;
        cfg_start = 0; cfg_stop = 0; irq_clr = 0;
        #12;
        checks++; if (timer_cnt !== '0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", timer_cnt); end
        checks++; if (timer_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", timer_busy); end
        checks++; if (timer_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", timer_done); end
        checks++; if (timer_irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b exp 0", timer_irq); end
        @(negedge clk);
        reset_n = 1'b1;
        cyc();
    endtask

    task automatic test_one_shot();
        cfg_mode = 0; cfg_clksel = 2'b00; cfg_load_val = 16'd5;
        for (int k = 0; k <= 5; k++) sb.push_back(mk(WD'(5 - k), 1'b1, 1'b0));
        sb.push_back(mk('0, 1'b0, 1'b1));
        sb.push_back(mk('0, 1'b0, 1'b0));
        cfg_start = 1;
        for (int i = 0; i < 8; i++) begin
            cyc();
            cfg_start = 0;
            e = sb.pop_front();
            checks++;
            if (timer_cnt !== e.cnt || timer_busy !== e.busy || timer_done !== e.done) begin
                errors++;
                $display("FAIL one_shot cyc%0d got cnt=%0d busy=%b done=%b exp cnt=%0d busy=%b done=%b",
                         i + 1, timer_cnt, timer_busy, timer_done, e.cnt, e.busy, e.done);
            end
        end
        checks++; if (timer_irq !== 1'b1) begin errors++; $display("FAIL one_shot_irq got %b exp 1", timer_irq); end
    endtask

    task automatic test_irq();
        irq_clr = 1; cyc(); irq_clr = 0;
        checks++; if (timer_irq !== 1'b0) begin errors++; $display("FAIL irq_clr_alone got %b exp 0", timer_irq); end
        cfg_mode = 0; cfg_clksel = 2'b00; cfg_load_val = '0;
        cfg_start = 1; cyc(); cfg_start = 0;
        irq_clr = 1; cyc(); irq_clr = 0;
        checks++; if (timer_done !== 1'b1) begin errors++; $display("FAIL irq_coincident_done got %b exp 1", timer_done); end
        checks++; if (timer_irq !== 1'b1) begin errors++; $display("FAIL irq_coincident got %b exp 1", timer_irq); end
        irq_clr = 1; cyc(); irq_clr = 0;
        checks++; if (timer_irq !== 1'b0) begin errors++; $display("FAIL irq_clr_after got %b exp 0", timer_irq); end
    endtask

    task automatic test_periodic();
        int ndone = 0;
        cfg_mode = 1; cfg_clksel = 2'b01; cfg_load_val = 16'd2;
        cfg_start = 1; cyc(); cfg_start = 0;
        checks++; if (timer_cnt !== 16'd2 || timer_busy !== 1'b1) begin
            errors++; $display("FAIL periodic_start got cnt=%0d busy=%b exp cnt=2 busy=1", timer_cnt, timer_busy);
        end
        for (int k = 0; k < 30; k++) begin
            repeat (49) begin
                cyc();
                if (timer_done) ndone++;
            end
            pulse_1us = 1;
            sb.push_back(mk((k % 3 == 0) ? 16'd1 : (k % 3 == 1) ? 16'd0 : 16'd2, 1'b1, (k % 3 == 2)));
            cyc();
            pulse_1us = 0;
            if (timer_done) ndone++;
            e = sb.pop_front();
            checks++;
            if (timer_cnt !== e.cnt || timer_busy !== e.busy || timer_done !== e.done) begin
                errors++;
                $display("FAIL periodic tick%0d got cnt=%0d busy=%b done=%b exp cnt=%0d busy=%b done=%b",
                         k, timer_cnt, timer_busy, timer_done, e.cnt, e.busy, e.done);
            end
        end
        checks++; if (ndone != 10) begin errors++; $display("FAIL periodic_count got %0d exp 10", ndone); end
        cfg_stop = 1; cyc(); cfg_stop = 0;
        checks++; if (timer_busy !== 1'b0) begin errors++; $display("FAIL periodic_stop got busy=%b exp 0", timer_busy); end
        irq_clr = 1; cyc(); irq_clr = 0;
    endtask

    task automatic test_clksel();
        cfg_mode = 0; cfg_clksel = 2'b10; cfg_load_val = 16'd1;
        cfg_start = 1; cyc(); cfg_start = 0;
        pulse_1us = 1; pulse_1s = 1; cyc(); pulse_1us = 0; pulse_1s = 0;
        checks++; if (timer_cnt !== 16'd1) begin errors++; $display("FAIL clksel_ms_hold got %0d exp 1", timer_cnt); end
        pulse_1ms = 1; cyc();
        checks++; if (timer_cnt !== 16'd0 || timer_busy !== 1'b1) begin
            errors++; $display("FAIL clksel_ms_dec got cnt=%0d busy=%b exp cnt=0 busy=1", timer_cnt, timer_busy);
        end
        cyc(); pulse_1ms = 0;
        checks++; if (timer_done !== 1'b1 || timer_busy !== 1'b0) begin
            errors++; $display("FAIL clksel_ms_exp got done=%b busy=%b exp done=1 busy=0", timer_done, timer_busy);
        end
        cfg_clksel = 2'b11; cfg_load_val = '0;
        cfg_start = 1; cyc(); cfg_start = 0;
        pulse_1ms = 1; cyc(); pulse_1ms = 0;
        checks++; if (timer_done !== 1'b0 || timer_busy !== 1'b1) begin
            errors++; $display("FAIL clksel_s_hold got done=%b busy=%b exp done=0 busy=1", timer_done, timer_busy);
        end
        pulse_1s = 1; cyc(); pulse_1s = 0;
        checks++; if (timer_done !== 1'b1 || timer_busy !== 1'b0) begin
            errors++; $display("FAIL clksel_s_exp got done=%b busy=%b exp done=1 busy=0", timer_done, timer_busy);
        end
        irq_clr = 1; cyc(); irq_clr = 0;
    endtask

    task automatic test_stop_priority();
        cfg_mode = 0; cfg_clksel = 2'b01; cfg_load_val = 16'd1;
        cfg_start = 1; cfg_stop = 1; cyc(); cfg_start = 0; cfg_stop = 0;
        checks++; if (timer_busy !== 1'b0) begin errors++; $display("FAIL stop_prio_idle got busy=%b exp 0", timer_busy); end
        cfg_start = 1; cyc(); cfg_start = 0;
        pulse_1us = 1; cyc();
        checks++; if (timer_cnt !== 16'd0 || timer_busy !== 1'b1) begin
            errors++; $display("FAIL stop_prep got cnt=%0d busy=%b exp cnt=0 busy=1", timer_cnt, timer_busy);
        end
        cfg_stop = 1; cyc(); cfg_stop = 0; pulse_1us = 0;
        checks++; if (timer_done !== 1'b0 || timer_busy !== 1'b0 || timer_irq !== 1'b0) begin
            errors++; $display("FAIL stop_at_zero got done=%b busy=%b irq=%b exp 0 0 0", timer_done, timer_busy, timer_irq);
        end
        cyc();
        checks++; if (timer_done !== 1'b0) begin errors++; $display("FAIL stop_after got done=%b exp 0", timer_done); end
    endtask

    task automatic test_restart();
        cfg_mode = 0; cfg_clksel = 2'b00; cfg_load_val = 16'd10;
        cfg_start = 1; cyc(); cfg_start = 0;
        repeat (4) cyc();
        checks++; if (timer_cnt !== 16'd6) begin errors++; $display("FAIL restart_pre got %0d exp 6", timer_cnt); end
        for (int k = 0; k <= 10; k++) sb.push_back(mk(WD'(10 - k), 1'b1, 1'b0));
        sb.push_back(mk('0, 1'b0, 1'b1));
        cfg_start = 1;
        for (int i = 0; i < 12; i++) begin
            cyc();
            cfg_start = 0;
            e = sb.pop_front();
            checks++;
            if (timer_cnt !== e.cnt || timer_busy !== e.busy || timer_done !== e.done) begin
                errors++;
                $display("FAIL restart cyc%0d got cnt=%0d busy=%b done=%b exp cnt=%0d busy=%b done=%b",
                         i, timer_cnt, timer_busy, timer_done, e.cnt, e.busy, e.done);
            end
        end
    endtask

    task automatic test_enable();
        cfg_mode = 0; cfg_clksel = 2'b00; cfg_load_val = 16'd5;
        cfg_start = 1; cyc(); cfg_start = 0;
        cyc(); cyc();
        cfg_enb = 0; cyc();
        checks++; if (timer_busy !== 1'b0 || timer_cnt !== 16'd3 || timer_irq !== 1'b1) begin
            errors++; $display("FAIL enb_off got busy=%b cnt=%0d irq=%b exp busy=0 cnt=3 irq=1", timer_busy, timer_cnt, timer_irq);
        end
        cfg_start = 1; cyc(); cfg_start = 0;
        checks++; if (timer_busy !== 1'b0 || timer_cnt !== 16'd3) begin
            errors++; $display("FAIL enb_start_ignored got busy=%b cnt=%0d exp busy=0 cnt=3", timer_busy, timer_cnt);
        end
        cfg_enb = 1;
    endtask

    task automatic test_reset_mid_run();
        int ndone = 0;
        cfg_mode = 0; cfg_clksel = 2'b00; cfg_load_val = 16'd10;
        cfg_start = 1; cyc(); cfg_start = 0;
        repeat (3) cyc();
        checks++; if (timer_cnt !== 16'd7 || timer_irq !== 1'b1) begin
            errors++; $display("FAIL rst_prep got cnt=%0d irq=%b exp cnt=7 irq=1", timer_cnt, timer_irq);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (timer_cnt !== '0 || timer_busy !== 1'b0 || timer_done !== 1'b0 || timer_irq !== 1'b0) begin
            errors++; $display("FAIL rst_mid_run got cnt=%0d busy=%b done=%b irq=%b exp all 0",
                               timer_cnt, timer_busy, timer_done, timer_irq);
        end
        cyc(); cyc();
        reset_n = 1'b1;
        repeat (15) begin
            cyc();
            if (timer_done || timer_busy) ndone++;
        end
        checks++; if (ndone != 0) begin errors++; $display("FAIL rst_no_resume got %0d active cycles exp 0", ndone); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_one_shot();
        test_irq();
        test_periodic();
        test_clksel();
        test_stop_priority();
        test_restart();
        test_enable();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
